// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: opcodes, instruction field
// positions, default fetch geometry and a jump-detect helper.
package isa_pkg;

  localparam int ISA_ADDR_W   = 6;
  localparam int ISA_INST_W   = 32;
  localparam int ISA_RESET_PC = 0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_AND   = 6'b000001,
    OP_ADDI  = 6'b000101,
    OP_LOAD  = 6'b001101,
    OP_BEQ   = 6'b001111,
    OP_JUMP  = 6'b010010
  } opcode_e;

  // Field slices as [hi:lo] bit positions within a 32-bit instruction word.
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int FUNC_HI  = 25;
  localparam int FUNC_LO  = 20;
  localparam int SHAMT_HI = 19;
  localparam int SHAMT_LO = 15;
  localparam int RD_HI    = 14;
  localparam int RD_LO    = 10;
  localparam int RS_HI    = 9;
  localparam int RS_LO    = 5;
  localparam int RT_HI    = 4;
  localparam int RT_LO    = 0;
  localparam int IMM_HI   = 25;
  localparam int IMM_LO   = 10;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_JUMP);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handshake: a valid/ready stream of {instruction, pc} entries.
interface inst_fetch_if #(
  parameter int ADDR_W = 6,
  parameter int INST_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output out_valid,
    output out_inst,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_inst,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry circular FIFO holding fetched {inst, pc} entries; flush empties it
// in one edge and the head reads as zero whenever the buffer is empty.
module fetch_buf #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  // Pointer and occupancy update; a flush behaves like reset for these.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_wptr <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Storage write; when full with a pop the new word lands in the slot being freed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (i_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Head presentation, zeroed while empty so stale flushed data never shows.
  always_comb begin
    o_head = '0;
    if (r_count != 2'd0) begin
      o_head = r_mem[r_rptr];
    end else begin
      o_head = '0;
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch unit: owns the PC, reads the combinational ROM, resolves
// unconditional jumps locally and takes taken-branch redirects from execute.
module inst_fetch #(
  parameter int          ADDR_W   = isa_pkg::ISA_ADDR_W,
  parameter int          INST_W   = isa_pkg::ISA_INST_W,
  parameter int unsigned RESET_PC = isa_pkg::ISA_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] o_rom_a,
  input  logic [INST_W-1:0] i_rom_inst,
  inst_fetch_if.master      dec_if,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_busy
);

  import isa_pkg::*;

  localparam int ENT_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_push;
  logic              w_pop;
  logic              w_jump;
  logic              w_head_valid;
  logic [1:0]        w_count;
  logic [ENT_W-1:0]  w_head;

  assign w_pop  = w_head_valid & dec_if.out_ready;
  assign w_push = !i_redirect_valid & ((w_count < 2'd2) | w_pop);
  assign w_jump = is_jump(i_rom_inst[OP_HI:OP_LO]);

  // Next-PC priority: redirect, then jump target, then sequential, else hold on stall.
  always_comb begin
    w_next_pc = r_pc;
    if (i_redirect_valid) begin
      w_next_pc = i_redirect_pc;
    end else if (w_push && w_jump) begin
      w_next_pc = i_rom_inst[ADDR_W-1:0];
    end else if (w_push) begin
      w_next_pc = r_pc + ADDR_W'(1);
    end else begin
      w_next_pc = r_pc;
    end
  end

  // PC register; reset wins over any same-cycle redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC[ADDR_W-1:0];
    end else begin
      r_pc <= w_next_pc;
    end
  end

  fetch_buf #(
    .W (ENT_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_rom_inst, r_pc}),
    .o_valid (w_head_valid),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign o_rom_a          = r_pc;
  assign o_busy           = (w_count != 2'd0);
  assign dec_if.out_valid = w_head_valid;
  assign dec_if.out_inst  = w_head[ENT_W-1:ADDR_W];
  assign dec_if.out_pc    = w_head[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: straight-line, jump, redirect flush,
// backpressure, PC wrap and reset-over-redirect, all with hand-computed values.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  rom_a;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        busy;
  logic [31:0] rom [64];

  int n_checks;
  int n_errors;

  inst_fetch_if #(.ADDR_W(6), .INST_W(32)) dec_if ();

  inst_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .o_rom_a          (rom_a),
    .i_rom_inst       (rom_inst),
    .dec_if           (dec_if),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_busy           (busy)
  );

  assign rom_inst = rom[rom_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [5:0] exp_pc);
    check_eq({tag, "_valid"}, 32'(dec_if.out_valid), 32'd1);
    check_eq({tag, "_pc"}, 32'(dec_if.out_pc), 32'(exp_pc));
    check_eq({tag, "_inst"}, dec_if.out_inst, rom[exp_pc]);
  endtask

  logic [5:0] seq_pc [8]   = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd1, 6'd2};
  logic       bp_rdy [6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [5:0] bp_pc  [6]   = '{6'd8, 6'd8, 6'd8, 6'd9, 6'd10, 6'd10};
  logic [5:0] bp_roma [6]  = '{6'd9, 6'd10, 6'd10, 6'd11, 6'd12, 6'd12};
  logic [5:0] wr_pc  [4]   = '{6'd62, 6'd63, 6'd0, 6'd1};

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 64; i++) begin
      rom[i] = 32'h1400_0000 | 32'(i);
    end
    rom[0]  = 32'h0000_0000;
    rom[1]  = 32'h0022_0C41;
    rom[2]  = 32'h0440_1043;
    rom[3]  = 32'h0000_0000;
    rom[4]  = 32'h0000_0000;
    rom[5]  = 32'h4800_0001;
    rom[62] = 32'h0000_0000;
    rom[63] = 32'h0000_0000;

    rst               = 1'b1;
    redirect_valid    = 1'b0;
    redirect_pc       = 6'd0;
    dec_if.out_ready  = 1'b0;
    step();
    step();
    check_eq("rst_valid", 32'(dec_if.out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_inst", dec_if.out_inst, 32'd0);
    check_eq("rst_pc", 32'(dec_if.out_pc), 32'd0);
    check_eq("rst_roma", 32'(rom_a), 32'd0);

    // Straight-line then jump at word 5 back to word 1, one per cycle.
    rst              = 1'b0;
    dec_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_head("seq", seq_pc[k]);
    end

    // Fill to two entries, then redirect to 6.
    dec_if.out_ready = 1'b0;
    step();
    check_head("fill", 6'd2);
    check_eq("fill_busy", 32'(busy), 32'd1);
    check_eq("fill_roma", 32'(rom_a), 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 6'd6;
    step();
    check_eq("flush_valid", 32'(dec_if.out_valid), 32'd0);
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_roma", 32'(rom_a), 32'd6);
    redirect_valid   = 1'b0;
    dec_if.out_ready = 1'b1;
    step();
    check_head("redir0", 6'd6);
    step();
    check_head("redir1", 6'd7);

    // Backpressure pattern 1,0,0,1,1,0 then drain.
    for (int k = 0; k < 6; k++) begin
      dec_if.out_ready = bp_rdy[k];
      step();
      check_head("bp", bp_pc[k]);
      check_eq("bp_roma", 32'(rom_a), 32'(bp_roma[k]));
    end
    dec_if.out_ready = 1'b1;
    step();
    check_head("drain0", 6'd11);
    step();
    check_head("drain1", 6'd12);

    // Redirect to 62 and wrap through 63 -> 0.
    redirect_valid = 1'b1;
    redirect_pc    = 6'd62;
    step();
    check_eq("wrap_flush_valid", 32'(dec_if.out_valid), 32'd0);
    check_eq("wrap_roma", 32'(rom_a), 32'd62);
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_head("wrap", wr_pc[k]);
    end

    // Reset with a full buffer and a concurrent redirect.
    dec_if.out_ready = 1'b0;
    step();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_roma", 32'(rom_a), 32'd3);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 6'd40;
    step();
    check_eq("mrst_valid", 32'(dec_if.out_valid), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_roma", 32'(rom_a), 32'd0);
    check_eq("mrst_pc", 32'(dec_if.out_pc), 32'd0);
    rst              = 1'b0;
    redirect_valid   = 1'b0;
    dec_if.out_ready = 1'b1;
    step();
    check_head("post_rst", 6'd0);
    check_eq("post_rst_roma", 32'(rom_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
